decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Decode stage directly downstream of the fetch instruction queue. Consumes {addr, inst, error, errty}
//  over a valid/ready handshake, decodes RV32I (+optional M) into a DecodedInst bundle, and presents it
//  to the issue/register-read stage through a 2-entry skid buffer. Killed by the same redirect (flush)
//  that kills the fetch queue.
// PARAMETERS
//  XLEN      32  data/address width; only 32 supported
//  FAULT_W   2   width of errty (FaultTy)
// PORTS
//  clk         in   1        single clock, rising edge
//  reset       in   1        asynchronous, active-high
//  flush       in   1        branch redirect; kills everything held or offered this cycle
//  in_valid    in   1        fetch queue has an instruction
//  in_ready    out  1        stage accepts in_* this cycle
//  in_addr     in   32       instruction PC
//  in_inst     in   32       raw instruction word
//  in_error    in   1        fetch fault flag
//  in_errty    in   FAULT_W  fetch fault type
//  out_valid   out  1        decoded bundle valid
//  out_ready   in   1        downstream accepts bundle
//  out_inst    out  DecodedInst  {addr, op, funct3, funct7b5, rd, rs1, rs2, imm, wb_en, is_br, is_jmp, illegal, error, errty}
// BEHAVIOUR
//  - Reset: both buffer entries invalid; out_valid=0, in_ready=1, out_inst all-zero.
//  - Latency 1: instruction accepted at edge N appears on out_* after edge N (cycle N+1).
//  - Handshake: transfer on valid&ready at rising edge. out_* stable while out_valid&!out_ready.
//    in_ready is a registered signal: in_ready = !skid_full. Never combinationally depends on out_ready.
//  - Buffer: main reg + skid reg. If main is full and not draining, an accepted input goes to skid;
//    on drain, skid moves to main. Order is strictly preserved; no drop, no duplicate.
//  - Flush: at the edge, both entries are invalidated, and in_* offered in the flush cycle is discarded.
//    out_valid=0 and in_ready=1 in the next cycle. Flush has priority over every simultaneous event.
//  - Decode: imm is sign-extended per format I/S/B/U/J (B/J are LSB-zero). op is one of
//    ALU, ALUI, LOAD, STORE, BR, JAL, JALR, LUI, AUIPC, SYS, FENCE, MULDIV.
//    wb_en=0 when rd==0 or op is STORE/BR/FENCE. is_br for BR; is_jmp for JAL/JALR.
//  - Illegal: unknown opcode, JALR with funct3!=0, bad funct7 on ALU, or bad funct3 on LOAD/STORE/BR.
//    These set illegal=1 and wb_en=0.
//  - Fetch fault: if in_error=1, error/errty pass through, illegal is forced 0, op=SYS, wb_en=0,
//    and inst bits are ignored.
//  - Full/empty: both entries full -> in_ready=0. Simultaneous push and pop while full-main/empty-skid
//    keeps skid empty.
//  - Reset asserted mid-transfer: state clears immediately (async); deassert is synchronous to clk.
// CONFIGURATION
//  RV_M_EN defined   : opcode 0110011 with funct7=0000001 decodes as op=MULDIV, with funct3 carried in
//                      funct3 and wb_en per rd.
//  RV_M_EN undefined : the same encodings are illegal=1, wb_en=0. Nothing else changes.
// STRUCTURE
//  - decode_pkg: OpClass enum, opcode constants (LUI/AUIPC/JAL/JALR/BR/LOAD/STORE/OPIMM/OP/FENCE/SYSTEM),
//    DecodedInst packed struct, and FaultTy.
//  - Sub-module decode_comb: purely combinational inst -> DecodedInst. decode_stage owns only the
//    handshake and the skid buffer.
// TESTING
//  1. addi x1,x0,5 (0x00500093) @addr 0x100, out_ready=1 -> next cycle out_valid=1, op=ALUI, rd=1,
//     rs1=0, imm=0x00000005, wb_en=1.
//  2. beq x0,x0,-4 (0xFE000EE3) -> op=BR, is_br=1, imm=0xFFFFFFFC, wb_en=0, illegal=0.
//  3. mul x3,x1,x2 (0x022081B3) -> with RV_M_EN: op=MULDIV, rd=3, wb_en=1; without RV_M_EN: illegal=1,
//     wb_en=0.
//  4. out_ready=0 for 3 cycles while 3 instructions are offered back to back -> 2 accepted, then
//     in_ready=0; after out_ready=1 all 3 emerge in order with no duplicates.
//  5. flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; none of the
//     3 instructions ever appears.
//  6. in_error=1, errty=1, inst=0xFFFFFFFF -> error=1, errty=1, illegal=0, wb_en=0; reset asserted
//     mid-stream -> out_valid=0 without waiting for a clk edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I(+M) decode stage.
//   fault_ty_t     : fetch fault type carried alongside each instruction
//   op_class_t     : coarse operation class handed to issue
//   OPC_*          : 7-bit major opcodes
//   decoded_inst_t : decoded bundle presented downstream
package decode_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned FAULT_W = 2;

  typedef logic [FAULT_W-1:0] fault_ty_t;

  typedef enum logic [3:0] {
    OP_ALU,
    OP_ALUI,
    OP_LOAD,
    OP_STORE,
    OP_BR,
    OP_JAL,
    OP_JALR,
    OP_LUI,
    OP_AUIPC,
    OP_SYS,
    OP_FENCE,
    OP_MULDIV
  } op_class_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BR     = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    op_class_t       op;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            wb_en;
    logic            is_br;
    logic            is_jmp;
    logic            illegal;
    logic            error;
    fault_ty_t       errty;
  } decoded_inst_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I(+M) decoder: {addr, inst, error, errty} -> decoded_inst_t.
// Ports:
//   addr  in  : instruction PC (passed through)
//   inst  in  : raw instruction word
//   error in  : fetch fault; when set, inst is ignored and op=SYS
//   errty in  : fetch fault type (passed through)
//   dec   out : decoded bundle
// Configuration: define RV_M_EN to decode OP/funct7=0000001 as MULDIV;
// otherwise those encodings are illegal.
// Register fields are extracted raw for every format; illegal encodings keep
// their natural class (unknown opcodes report SYS) and never write back.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0]   addr,
  input  logic [31:0]   inst,
  input  logic          error,
  input  fault_ty_t     errty,
  output decoded_inst_t dec
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  assign imm_i = {{21{inst[31]}}, inst[30:20]};
  assign imm_s = {{21{inst[31]}}, inst[30:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec       = '0;
    dec.addr  = addr;
    dec.error = error;
    dec.errty = errty;
    if (error) begin
      dec.op = OP_SYS;
    end else begin
      dec.funct3   = f3;
      dec.funct7b5 = inst[30];
      dec.rd       = inst[11:7];
      dec.rs1      = inst[19:15];
      dec.rs2      = inst[24:20];
      case (opcode)
        OPC_LUI:    begin dec.op = OP_LUI;   dec.imm = imm_u; end
        OPC_AUIPC:  begin dec.op = OP_AUIPC; dec.imm = imm_u; end
        OPC_JAL:    begin dec.op = OP_JAL;   dec.imm = imm_j; end
        OPC_JALR: begin
          dec.op      = OP_JALR;
          dec.imm     = imm_i;
          dec.illegal = (f3 != 3'b000);
        end
        OPC_BR: begin
          dec.op      = OP_BR;
          dec.imm     = imm_b;
          dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
        end
        OPC_LOAD: begin
          dec.op      = OP_LOAD;
          dec.imm     = imm_i;
          dec.illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        end
        OPC_STORE: begin
          dec.op      = OP_STORE;
          dec.imm     = imm_s;
          dec.illegal = (f3[2] || f3 == 3'b011);
        end
        OPC_OPIMM:  begin dec.op = OP_ALUI;  dec.imm = imm_i; end
        OPC_OP: begin
          dec.op = OP_ALU;
          if (f7 == 7'b0000001) begin
`ifdef RV_M_EN
            dec.op = OP_MULDIV;
`else
            dec.illegal = 1'b1;
`endif
          end else if (f7 == 7'b0100000) begin
            // Only SUB and SRA use the alternate funct7.
            dec.illegal = !((f3 == 3'b000) || (f3 == 3'b101));
          end else begin
            dec.illegal = (f7 != 7'b0000000);
          end
        end
        OPC_FENCE:  begin dec.op = OP_FENCE; dec.imm = imm_i; end
        OPC_SYSTEM: begin dec.op = OP_SYS;   dec.imm = imm_i; end
        default: begin
          dec.op      = OP_SYS;
          dec.illegal = 1'b1;
        end
      endcase
      dec.wb_en  = !dec.illegal && (dec.rd != 5'd0) &&
                   !(dec.op inside {OP_STORE, OP_BR, OP_FENCE});
      dec.is_br  = !dec.illegal && (dec.op == OP_BR);
      dec.is_jmp = !dec.illegal && (dec.op inside {OP_JAL, OP_JALR});
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage between the fetch instruction queue and issue/register-read.
// Accepts {addr, inst, error, errty} on a valid/ready handshake, decodes it
// through decode_comb and presents the bundle via a 2-entry skid buffer
// (main + skid). in_ready is !skid_valid, so it never depends on out_ready
// combinationally. flush drops both entries and the input offered that cycle.
// Ports:
//   clk, reset (async, active-high), flush
//   in_valid/in_ready, in_addr, in_inst, in_error, in_errty : upstream
//   out_valid/out_ready, out_inst                           : downstream
// Configuration: RV_M_EN enables M-extension decode in decode_comb.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned FAULT_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_addr,
  input  logic [31:0]        in_inst,
  input  logic               in_error,
  input  logic [FAULT_W-1:0] in_errty,
  output logic               out_valid,
  input  logic               out_ready,
  output decoded_inst_t      out_inst
);

  decoded_inst_t dec, main_q, skid_q;
  logic          main_v, skid_v;
  logic          push, pop;

  decode_comb u_decode_comb (
    .addr  (in_addr),
    .inst  (in_inst),
    .error (in_error),
    .errty (in_errty),
    .dec   (dec)
  );

  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_inst  = main_q;
  assign push      = in_valid && !skid_v;
  assign pop       = main_v && out_ready;

  // skid_v implies main_v, so skid is only ever loaded while main stalls and
  // only ever drained into main; a push while skid is full cannot happen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || pop) begin
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        main_v <= push;
        if (push) main_q <= dec;
      end
    end else if (push) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import decode_pkg::*;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_error, out_ready;
  logic          in_ready, out_valid;
  logic [31:0]   in_addr, in_inst;
  logic [1:0]    in_errty;
  decoded_inst_t out_inst;

  int unsigned   n_checks = 0;
  int unsigned   n_errs   = 0;
  decoded_inst_t exp_q[$];
  logic          stalled = 1'b0;
  decoded_inst_t held;

  logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                            7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .FAULT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_inst   (in_inst),
    .in_error  (in_error),
    .in_errty  (in_errty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode computed from the ISA field rules with integer arithmetic.
  function automatic decoded_inst_t model(input logic [31:0] a, input logic [31:0] w,
                                          input logic e, input logic [1:0] t);
    decoded_inst_t d;
    int   iv;
    logic [2:0] f3;
    logic [6:0] f7;
    d = '0;
    d.addr = a; d.error = e; d.errty = t;
    if (e) begin
      d.op = OP_SYS;
      return d;
    end
    f3 = w[14:12];
    f7 = w[31:25];
    d.funct3 = f3; d.funct7b5 = w[30];
    d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
    iv = 0;
    case (w[6:0])
      7'h37: begin d.op = OP_LUI;   iv = int'(w[31:12]) * 4096; end
      7'h17: begin d.op = OP_AUIPC; iv = int'(w[31:12]) * 4096; end
      7'h6F: begin
        d.op = OP_JAL;
        iv = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
             + int'(w[30:21]) * 2;
      end
      7'h67: begin
        d.op = OP_JALR; d.illegal = (f3 != 0);
        iv = (w[31] ? -2048 : 0) + int'(w[30:20]);
      end
      7'h63: begin
        d.op = OP_BR; d.illegal = (f3 inside {3'd2, 3'd3});
        iv = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
             + int'(w[11:8]) * 2;
      end
      7'h03: begin
        d.op = OP_LOAD; d.illegal = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        iv = (w[31] ? -2048 : 0) + int'(w[30:20]);
      end
      7'h23: begin
        d.op = OP_STORE; d.illegal = !(f3 inside {3'd0, 3'd1, 3'd2});
        iv = (w[31] ? -2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:7]);
      end
      7'h13: begin d.op = OP_ALUI; iv = (w[31] ? -2048 : 0) + int'(w[30:20]); end
      7'h33: begin
        d.op = OP_ALU;
        if (f7 == 7'h01) begin
`ifdef RV_M_EN
          d.op = OP_MULDIV;
`else
          d.illegal = 1'b1;
`endif
        end else if (f7 == 7'h20) d.illegal = !(f3 inside {3'd0, 3'd5});
        else d.illegal = (f7 != 7'h00);
      end
      7'h0F: begin d.op = OP_FENCE; iv = (w[31] ? -2048 : 0) + int'(w[30:20]); end
      7'h73: begin d.op = OP_SYS;   iv = (w[31] ? -2048 : 0) + int'(w[30:20]); end
      default: begin d.op = OP_SYS; d.illegal = 1'b1; end
    endcase
    d.imm    = iv;
    d.wb_en  = !d.illegal && d.rd != 0 && !(d.op inside {OP_STORE, OP_BR, OP_FENCE});
    d.is_br  = !d.illegal && d.op == OP_BR;
    d.is_jmp = !d.illegal && (d.op == OP_JAL || d.op == OP_JALR);
    return d;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(9) != 0) w[6:0] = opcs[$urandom_range(10)];
    case ($urandom_range(3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  // Monitor/scoreboard: handshakes are sampled mid-cycle, ahead of the edge
  // that performs them.
  always @(negedge clk) begin
    if (reset || flush) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 128'(out_valid), 128'(1'b1));
        check("stall_hold", 128'(out_inst), 128'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 128'(out_inst), 128'(0));
        else check("out_inst", 128'(out_inst), 128'(exp_q.pop_front()));
      end
      stalled = out_valid && !out_ready;
      held    = out_inst;
      if (in_valid && in_ready) exp_q.push_back(model(in_addr, in_inst, in_error, in_errty));
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] w,
                      input logic e, input logic [1:0] t);
    int unsigned k;
    k = 0;
    in_valid = 1'b1; in_addr = a; in_inst = w; in_error = e; in_errty = t;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 50);
    check("send_accept", 128'(in_ready), 128'(1'b1));
    sync();
    in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_error = 1'b0; out_ready = 1'b1;
    in_addr = '0; in_inst = '0; in_errty = '0;
    #12;
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_in_ready", 128'(in_ready), 128'(1'b1));
    check("rst_out_inst", 128'(out_inst), 128'(0));
    sync();
    reset = 1'b0;
    sync();

    // addi x1,x0,5
    send(32'h100, 32'h00500093, 1'b0, 2'd0);
    @(negedge clk);
    check("t1_valid", 128'(out_valid), 128'(1'b1));
    check("t1_op", 128'(out_inst.op), 128'(OP_ALUI));
    check("t1_rd", 128'(out_inst.rd), 128'(5'd1));
    check("t1_imm", 128'(out_inst.imm), 128'(32'h5));
    check("t1_wb", 128'(out_inst.wb_en), 128'(1'b1));
    sync();

    // beq x0,x0,-4
    send(32'h104, 32'hFE000EE3, 1'b0, 2'd0);
    @(negedge clk);
    check("t2_op", 128'(out_inst.op), 128'(OP_BR));
    check("t2_isbr", 128'(out_inst.is_br), 128'(1'b1));
    check("t2_imm", 128'(out_inst.imm), 128'(32'hFFFFFFFC));
    check("t2_wb", 128'(out_inst.wb_en), 128'(1'b0));
    check("t2_illegal", 128'(out_inst.illegal), 128'(1'b0));
    sync();

    // mul x3,x1,x2
    send(32'h108, 32'h022081B3, 1'b0, 2'd0);
    @(negedge clk);
    check("t3_rd", 128'(out_inst.rd), 128'(5'd3));
`ifdef RV_M_EN
    check("t3_op", 128'(out_inst.op), 128'(OP_MULDIV));
    check("t3_wb", 128'(out_inst.wb_en), 128'(1'b1));
`else
    check("t3_illegal", 128'(out_inst.illegal), 128'(1'b1));
    check("t3_wb", 128'(out_inst.wb_en), 128'(1'b0));
`endif
    sync();

    // fetch fault
    send(32'h10C, 32'hFFFFFFFF, 1'b1, 2'd1);
    @(negedge clk);
    check("t6_error", 128'(out_inst.error), 128'(1'b1));
    check("t6_errty", 128'(out_inst.errty), 128'(2'd1));
    check("t6_illegal", 128'(out_inst.illegal), 128'(1'b0));
    check("t6_wb", 128'(out_inst.wb_en), 128'(1'b0));
    sync();

    // Back-pressure: three offered while downstream stalls.
    out_ready = 1'b0;
    send(32'h200, 32'h00100113, 1'b0, 2'd0);
    send(32'h204, 32'h00200193, 1'b0, 2'd0);
    check("t4_full_in_ready", 128'(in_ready), 128'(1'b0));
    in_valid = 1'b1; in_addr = 32'h208; in_inst = 32'h00300213; in_error = 1'b0;
    @(negedge clk);
    check("t4_still_full", 128'(in_ready), 128'(1'b0));
    sync();
    out_ready = 1'b1;
    send(32'h208, 32'h00300213, 1'b0, 2'd0);
    repeat (4) sync();
    check("t4_drained", 128'(exp_q.size()), 128'(0));

    // Flush with both entries full and a third offered.
    out_ready = 1'b0;
    send(32'h300, 32'h00400293, 1'b0, 2'd0);
    send(32'h304, 32'h00500313, 1'b0, 2'd0);
    in_valid = 1'b1; in_addr = 32'h308; in_inst = 32'h00600393; flush = 1'b1;
    sync();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t5_out_valid", 128'(out_valid), 128'(1'b0));
    check("t5_in_ready", 128'(in_ready), 128'(1'b1));
    sync();
    out_ready = 1'b1;
    repeat (4) sync();

    // Asynchronous reset with a bundle held.
    out_ready = 1'b0;
    send(32'h400, 32'h00700413, 1'b0, 2'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", 128'(out_valid), 128'(1'b0));
    check("t6_async_ready", 128'(in_ready), 128'(1'b1));
    sync();
    sync();
    reset = 1'b0;
    out_ready = 1'b1;
    sync();

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(9) < 7);
      in_addr   = $urandom();
      in_inst   = rand_inst();
      in_error  = ($urandom_range(7) == 0);
      in_errty  = 2'($urandom_range(3));
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(49) == 0);
      sync();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) sync();
    check("final_drain", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
